avalon_st_pkt_multiplier: RTL and testbench

//  Downstream consumer of the Avalon-ST master stream: an Avalon-ST sink/source pair around a sequential multiplier.

---
 rtl/avalon_st_pkt_multiplier.sv | 230 +++++++++++++++++++++++
 tb/tb_avalon_st_pkt_multiplier.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/avalon_st_pkt_multiplier.sv
// avalon_st_pkt_multiplier
//   Avalon-ST sink/source pair around a sequential shift-add multiplier.
//   The sink collects one operand packet of N = 2*SZ/DSZ symbols: A then B,
//   each least-significant symbol first. The unsigned 2*SZ-bit product A*B
//   is formed one multiplier bit per cycle over SZ cycles. It is then
//   returned as one N-symbol packet on the source side, LSB symbol first.
//
// Ports
//   clk, _rst           clock (posedge) and synchronous active-low reset
//   data_in/valid_in    sink symbol and valid
//   startofpacket_in    sink first-symbol marker
//   endofpacket_in      sink last-symbol marker
//   ready_out           sink ready, ready latency 0 (high in IDLE and RX)
//   data_out/valid_out  source symbol and valid
//   startofpacket_out   source first-symbol marker
//   endofpacket_out     source last-symbol marker
//   ready_in            source ready from consumer, ready latency 0
//   busy                high while multiplying or transmitting
//   err_cnt             dropped malformed packets, saturates at 255
module avalon_st_pkt_multiplier #(
    parameter int unsigned SZ  = 32,
    parameter int unsigned DSZ = 8
) (
    input  logic           clk,
    input  logic           _rst,
    input  logic [DSZ-1:0] data_in,
    input  logic           valid_in,
    output logic           ready_out,
    input  logic           startofpacket_in,
    input  logic           endofpacket_in,
    output logic [DSZ-1:0] data_out,
    output logic           valid_out,
    input  logic           ready_in,
    output logic           startofpacket_out,
    output logic           endofpacket_out,
    output logic           busy,
    output logic [7:0]     err_cnt
);

    localparam int unsigned N  = 2 * SZ / DSZ;
    localparam int unsigned PW = 2 * SZ;
    localparam int unsigned IW = $clog2(N + 1);
    localparam int unsigned CW = $clog2(SZ + 1);

    generate
        if ((SZ % DSZ) != 0) begin : g_bad_width
            $error("avalon_st_pkt_multiplier: SZ must be a multiple of DSZ");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, RX, MUL, TX} state_t;

    state_t          state_q, state_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [PW-1:0]   opnd_q, opnd_d;       // {B,A} as collected
    logic [PW-1:0]   mcand_q, mcand_d;     // A, shifted left each MUL cycle
    logic [SZ-1:0]   mplier_q, mplier_d;   // B, shifted right each MUL cycle
    logic [PW-1:0]   acc_q, acc_d;
    logic [7:0]      err_cnt_q, err_cnt_d;
    logic            ready_out_q, ready_out_d;
    logic            valid_out_q, valid_out_d;
    logic [DSZ-1:0]  data_out_q, data_out_d;
    logic            sop_out_q, sop_out_d;
    logic            eop_out_q, eop_out_d;
    logic            busy_q, busy_d;

    logic            sink_beat;
    logic            src_beat;
    logic            err_inc;
    logic [PW-1:0]   opnd_full;            // operands including the final symbol

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        cnt_d       = cnt_q;
        opnd_d      = opnd_q;
        mcand_d     = mcand_q;
        mplier_d    = mplier_q;
        acc_d       = acc_q;
        err_cnt_d   = err_cnt_q;
        valid_out_d = valid_out_q;
        data_out_d  = data_out_q;
        sop_out_d   = sop_out_q;
        eop_out_d   = eop_out_q;
        err_inc     = 1'b0;

        sink_beat = valid_in & ready_out_q;
        src_beat  = valid_out_q & ready_in;

        opnd_full = opnd_q;
        opnd_full[PW-1 -: DSZ] = data_in;

        case (state_q)
            IDLE: begin
                if (sink_beat && startofpacket_in) begin
                    if (endofpacket_in) begin
                        err_inc = 1'b1;
                    end else begin
                        opnd_d[DSZ-1:0] = data_in;
                        idx_d           = IW'(1);
                        state_d         = RX;
                    end
                end
            end

            RX: begin
                if (sink_beat) begin
                    if (startofpacket_in) begin
                        // Restart: the aborted packet counts as an error; a
                        // restart that is also eop is a single-symbol drop.
                        err_inc = 1'b1;
                        if (endofpacket_in) begin
                            state_d = IDLE;
                        end else begin
                            opnd_d[DSZ-1:0] = data_in;
                            idx_d           = IW'(1);
                        end
                    end else if (idx_q == IW'(N - 1)) begin
                        if (endofpacket_in) begin
                            mcand_d  = {{SZ{1'b0}}, opnd_full[SZ-1:0]};
                            mplier_d = opnd_full[PW-1:SZ];
                            acc_d    = '0;
                            cnt_d    = '0;
                            state_d  = MUL;
                        end else begin
                            err_inc = 1'b1;
                            state_d = IDLE;
                        end
                    end else if (endofpacket_in) begin
                        err_inc = 1'b1;
                        state_d = IDLE;
                    end else begin
                        opnd_d[idx_q*DSZ +: DSZ] = data_in;
                        idx_d = idx_q + 1'b1;
                    end
                end
            end

            MUL: begin
                if (mplier_q[0]) begin
                    acc_d = acc_q + mcand_q;
                end
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + 1'b1;
                if (cnt_q == CW'(SZ - 1)) begin
                    idx_d   = '0;
                    state_d = TX;
                end
            end

            TX: begin
                // valid_out is low only on the first TX cycle, so that cycle
                // loads symbol 0; afterwards each source beat advances.
                if (!valid_out_q) begin
                    valid_out_d = 1'b1;
                    data_out_d  = acc_q[DSZ-1:0];
                    sop_out_d   = 1'b1;
                    eop_out_d   = 1'b0;
                    idx_d       = IW'(1);
                end else if (src_beat) begin
                    if (eop_out_q) begin
                        valid_out_d = 1'b0;
                        sop_out_d   = 1'b0;
                        eop_out_d   = 1'b0;
                        state_d     = IDLE;
                    end else begin
                        data_out_d = acc_q[idx_q*DSZ +: DSZ];
                        sop_out_d  = 1'b0;
                        eop_out_d  = (idx_q == IW'(N - 1));
                        idx_d      = idx_q + 1'b1;
                    end
                end
            end

            default: state_d = IDLE;
        endcase

        if (err_inc && (err_cnt_q != 8'hFF)) begin
            err_cnt_d = err_cnt_q + 8'd1;
        end

        ready_out_d = (state_d == IDLE) || (state_d == RX);
        busy_d      = (state_d == MUL) || (state_d == TX);
    end

    always_ff @(posedge clk) begin
        if (!_rst) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            cnt_q       <= '0;
            opnd_q      <= '0;
            mcand_q     <= '0;
            mplier_q    <= '0;
            acc_q       <= '0;
            err_cnt_q   <= '0;
            ready_out_q <= 1'b0;
            valid_out_q <= 1'b0;
            data_out_q  <= '0;
            sop_out_q   <= 1'b0;
            eop_out_q   <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            cnt_q       <= cnt_d;
            opnd_q      <= opnd_d;
            mcand_q     <= mcand_d;
            mplier_q    <= mplier_d;
            acc_q       <= acc_d;
            err_cnt_q   <= err_cnt_d;
            ready_out_q <= ready_out_d;
            valid_out_q <= valid_out_d;
            data_out_q  <= data_out_d;
            sop_out_q   <= sop_out_d;
            eop_out_q   <= eop_out_d;
            busy_q      <= busy_d;
        end
    end

    assign ready_out         = ready_out_q;
    assign valid_out         = valid_out_q;
    assign data_out          = data_out_q;
    assign startofpacket_out = sop_out_q;
    assign endofpacket_out   = eop_out_q;
    assign busy              = busy_q;
    assign err_cnt           = err_cnt_q;

endmodule

// File: tb/tb_avalon_st_pkt_multiplier.sv
// tb_avalon_st_pkt_multiplier
//   Directed and randomized operand packets for avalon_st_pkt_multiplier
//   (SZ=32, DSZ=8). Expected products come from 64-bit arithmetic and the
//   expected error count from the packet-framing rules.
module tb_avalon_st_pkt_multiplier;

    localparam int SZ  = 32;
    localparam int DSZ = 8;
    localparam int N   = 2 * SZ / DSZ;

    logic       clk;
    logic       rst_n;
    logic [7:0] data_in;
    logic       valid_in;
    logic       ready_out;
    logic       sop_in;
    logic       eop_in;
    logic [7:0] data_out;
    logic       valid_out;
    logic       ready_in;
    logic       sop_out;
    logic       eop_out;
    logic       busy;
    logic [7:0] err_cnt;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int exp_err  = 0;

    avalon_st_pkt_multiplier #(.SZ(SZ), .DSZ(DSZ)) dut (
        .clk               (clk),
        ._rst              (rst_n),
        .data_in           (data_in),
        .valid_in          (valid_in),
        .ready_out         (ready_out),
        .startofpacket_in  (sop_in),
        .endofpacket_in    (eop_in),
        .data_out          (data_out),
        .valid_out         (valid_out),
        .ready_in          (ready_in),
        .startofpacket_out (sop_out),
        .endofpacket_out   (eop_out),
        .busy              (busy),
        .err_cnt           (err_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_data"},  64'(data_out), 64'd0);
        check({tag, "_valid"}, 64'(valid_out), 64'd0);
        check({tag, "_ready"}, 64'(ready_out), 64'd0);
        check({tag, "_sop"},   64'(sop_out), 64'd0);
        check({tag, "_eop"},   64'(eop_out), 64'd0);
        check({tag, "_busy"},  64'(busy), 64'd0);
        check({tag, "_err"},   64'(err_cnt), 64'd0);
    endtask

    task automatic send_beat(input logic [7:0] d, input bit s, input bit e);
        int w = 0;
        data_in  = d;
        sop_in   = s;
        eop_in   = e;
        valid_in = 1'b1;
        while (!ready_out && w < 100) begin
            tick();
            w++;
        end
        if (w >= 100) check("sink_ready_timeout", 64'(ready_out), 64'd1);
        tick();
        valid_in = 1'b0;
        sop_in   = 1'b0;
        eop_in   = 1'b0;
    endtask

    task automatic send_pkt(input logic [63:0] ab, input int n_sym, input bit eop_last);
        for (int k = 0; k < n_sym; k++)
            send_beat(ab[k*8 +: 8], (k == 0), eop_last && (k == n_sym - 1));
    endtask

    task automatic quiet(input int n);
        bit seen = 0;
        ready_in = 1'b1;
        repeat (n) begin
            tick();
            if (valid_out) seen = 1;
        end
        check("no_output", 64'(seen), 64'd0);
    endtask

    task automatic recv_check(input logic [63:0] exp_p, input bit toggle, input int t_last);
        int waited = 0;
        ready_in = 1'b1;
        while (!valid_out && waited < 200) begin
            tick();
            waited++;
        end
        check("valid_out_rise", 64'(valid_out), 64'd1);
        check("rise_latency", 64'(cyc - t_last), 64'(SZ + 1));
        for (int k = 0; k < N; k++) begin
            bit done = 0;
            int guard = 0;
            while (!done && guard < 50) begin
                guard++;
                if (toggle) ready_in = ~ready_in;
                if (!ready_in) begin
                    logic [7:0] d0;
                    logic s0, e0;
                    d0 = data_out;
                    s0 = sop_out;
                    e0 = eop_out;
                    tick();
                    check("stall_valid", 64'(valid_out), 64'd1);
                    check("stall_data", 64'(data_out), 64'(d0));
                    check("stall_sop_eop", {62'd0, sop_out, eop_out}, {62'd0, s0, e0});
                end else begin
                    check("sym_valid", 64'(valid_out), 64'd1);
                    check("sym_data", 64'(data_out), 64'(exp_p[k*8 +: 8]));
                    check("sym_sop", 64'(sop_out), 64'(k == 0));
                    check("sym_eop", 64'(eop_out), 64'(k == N - 1));
                    if (!toggle && k == N - 1)
                        check("eop_latency", 64'(cyc - t_last), 64'(SZ + N));
                    tick();
                    done = 1;
                end
            end
            if (!done) check("tx_stall_bound", 64'(done), 64'd1);
        end
        check("post_tx_valid", 64'(valid_out), 64'd0);
        check("post_tx_ready", 64'(ready_out), 64'd1);
        check("post_tx_busy", 64'(busy), 64'd0);
    endtask

    task automatic run_mul(input logic [31:0] a, input logic [31:0] b, input bit toggle);
        logic [63:0] p;
        int t_last;
        p = {32'd0, a} * {32'd0, b};
        send_pkt({b, a}, N, 1'b1);
        t_last = cyc;
        check("mul_ready_low", 64'(ready_out), 64'd0);
        check("mul_busy", 64'(busy), 64'd1);
        recv_check(p, toggle, t_last);
        check("err_cnt", 64'(err_cnt), 64'(exp_err));
    endtask

    initial begin
        rst_n    = 1'b0;
        data_in  = '0;
        valid_in = 1'b0;
        sop_in   = 1'b0;
        eop_in   = 1'b0;
        ready_in = 1'b0;

        // reset state
        repeat (3) tick();
        check_all_zero("reset");
        rst_n = 1'b1;
        tick();
        check("idle_ready", 64'(ready_out), 64'd1);
        check("idle_busy", 64'(busy), 64'd0);

        // 1: reference product with ready held high
        run_mul(32'd10234, 32'd566, 1'b0);

        // 2: toggling ready_in
        run_mul(32'd32, 32'd12, 1'b1);

        // 3: largest operands, then zero operand
        run_mul(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        run_mul(32'd0, 32'hFFFF_FFFF, 1'b0);

        // 4: early eop, then sop mid-packet followed by a full packet
        send_pkt({$urandom, $urandom}, 4, 1'b1);
        exp_err++;
        quiet(40);
        check("err_after_early_eop", 64'(err_cnt), 64'(exp_err));
        send_pkt({$urandom, $urandom}, 3, 1'b0);
        exp_err++;
        run_mul(32'd123456, 32'd789, 1'b0);

        // 5: stray non-sop symbols, then a packet lacking eop
        repeat (3) send_beat(8'($urandom), 1'b0, 1'b0);
        check("err_after_strays", 64'(err_cnt), 64'(exp_err));
        send_pkt({$urandom, $urandom}, N, 1'b0);
        exp_err++;
        quiet(40);
        check("err_after_no_eop", 64'(err_cnt), 64'(exp_err));
        run_mul(32'hDEAD_BEEF, 32'h1234_5678, 1'b1);

        // 6a: reset mid-multiply
        send_pkt({32'd77, 32'd99}, N, 1'b1);
        repeat (10) tick();
        rst_n = 1'b0;
        tick();
        check_all_zero("rst_mul");
        rst_n = 1'b1;
        exp_err = 0;
        quiet(60);
        run_mul(32'd5000, 32'd7, 1'b0);

        // 6b: reset mid-transmit after two symbols
        begin
            int w = 0;
            send_pkt({32'hCAFE_F00D, 32'h0BAD_1DEA}, N, 1'b1);
            ready_in = 1'b0;
            while (!valid_out && w < 200) begin
                tick();
                w++;
            end
            check("tx_started", 64'(valid_out), 64'd1);
            ready_in = 1'b1;
            tick();
            tick();
            ready_in = 1'b0;
            rst_n = 1'b0;
            tick();
            check_all_zero("rst_tx");
            rst_n = 1'b1;
            quiet(60);
        end
        run_mul(32'hFFFF_0001, 32'h0000_FFFF, 1'b1);

        // randomized packets with random stray symbols and ready behaviour
        for (int i = 0; i < 12; i++) begin
            logic [31:0] a, b;
            a = $urandom;
            b = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 255)) : 32'($urandom);
            repeat ($urandom_range(0, 2)) send_beat(8'($urandom), 1'b0, 1'b0);
            run_mul(a, b, 1'($urandom_range(0, 1)));
        end

        // error counter saturation
        repeat (260) send_beat(8'($urandom), 1'b1, 1'b1);
        exp_err = (exp_err + 260 > 255) ? 255 : exp_err + 260;
        quiet(5);
        check("err_saturated", 64'(err_cnt), 64'(exp_err));
        run_mul(32'd3, 32'd5, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
